// File: rtl/sequence_detector_110110_if.sv
// -----------------------------------------------------------------------------
// sequence_detector_110110_if
// Serial bit-stream interface between a bit source and the 110110 detector.
//   din  : serial data bit, one per clock (source -> detector)
//   dout : one-cycle match strobe (detector -> consumer)
// Modports:
//   master : drives din, observes dout (stream source / testbench side)
//   slave  : observes din, drives dout (detector side)
// -----------------------------------------------------------------------------
interface sequence_detector_110110_if;
   logic din;
   logic dout;

   modport master (
      output din,
      input  dout
   );

   modport slave (
      input  din,
      output dout
   );
endinterface

// File: rtl/sequence_detector_110110.sv
// -----------------------------------------------------------------------------
// sequence_detector_110110
// Moore FSM that flags every occurrence of the serial pattern 1-1-0-1-1-0
// (first bit first). One input bit is sampled on each rising clock edge.
// dout is high for exactly one cycle, after the edge that samples the
// sixth bit of a match.
//
// Ports:
//   clk   : system clock, rising-edge sampling
//   reset : asynchronous, active-high; forces S0 and dout = 0
//   bus   : sequence_detector_110110_if.slave (din in, dout out)
//
// Configuration macro:
//   SEQ_DET_OVERLAP_EN : when defined, overlapping matches are detected
//                        (S6 --1--> S4); otherwise detection is
//                        non-overlapping (S6 --1--> S1).
// -----------------------------------------------------------------------------
module sequence_detector_110110 (
   input  logic                              clk,
   input  logic                              reset,
   sequence_detector_110110_if.slave         bus
);

   // States named by the longest matched prefix of 110110.
   typedef enum logic [2:0] {
      StS0 = 3'd0,  // none
      StS1 = 3'd1,  // "1"
      StS2 = 3'd2,  // "11"
      StS3 = 3'd3,  // "110"
      StS4 = 3'd4,  // "1101"
      StS5 = 3'd5,  // "11011"
      StS6 = 3'd6   // "110110" (match)
   } state_e;

   state_e state_q;
   state_e state_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StS0;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = StS0;
      unique case (state_q)
         StS0: state_d = bus.din ? StS1 : StS0;
         StS1: state_d = bus.din ? StS2 : StS0;
         // Extra 1s keep the last two as a valid "11" prefix.
         StS2: state_d = bus.din ? StS2 : StS3;
         StS3: state_d = bus.din ? StS4 : StS0;
         StS4: state_d = bus.din ? StS5 : StS0;
         StS5: state_d = bus.din ? StS2 : StS6;
`ifdef SEQ_DET_OVERLAP_EN
         // Trailing "110" of the match doubles as the next prefix.
         StS6: state_d = bus.din ? StS4 : StS0;
`else
         // Match bits are consumed; only the new bit may start a prefix.
         StS6: state_d = bus.din ? StS1 : StS0;
`endif
         // Unused code 3'd7 falls back to S0.
         default: state_d = StS0;
      endcase
   end

   // Pure decode of the state register: no combinational path from din.
   assign bus.dout = (state_q == StS6);

endmodule

// File: tb/tb_sequence_detector_110110.sv
// -----------------------------------------------------------------------------
// tb_sequence_detector_110110
// Scoreboard bench: the stimulus process pushes the hand-computed expected
// dout for every bit it drives; a monitor process pops one entry per clock
// and compares it against dout shortly after the sampling edge.
// -----------------------------------------------------------------------------
module tb_sequence_detector_110110;

   logic clk;
   logic reset;

   sequence_detector_110110_if sd_if ();

   sequence_detector_110110 dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sd_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic   exp_q[$];
   int     n_total = 0;
   int     n_pass  = 0;
   int     n_fail  = 0;

   task automatic check(input string name, input logic act, input logic exp);
      n_total++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: dout=%b expected=%b at %0t", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Monitor: one comparison per clock while expectations are pending.
   string cur_test = "init";
   initial begin
      logic e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(cur_test, sd_if.dout, e);
         end
      end
   end

   // Drive each character of bits on successive negedges, queueing the
   // matching character of exps as the dout expected after that edge.
   task automatic send(input string name, input string bits, input string exps);
      cur_test = name;
      for (int i = 0; i < bits.len(); i++) begin
         @(negedge clk);
         sd_if.din = (bits[i] == "1");
         exp_q.push_back(exps[i] == "1");
      end
   endtask

   // One-cycle synchronous-looking reset pulse placed after the last
   // pending comparison has been made.
   task automatic pulse_reset();
      @(posedge clk);
      #2;
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, n_pass=%0d required_total=%0d",
               n_pass, n_total);
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset     = 1'b1;
      sd_if.din = 1'b0;

      // Reset held for 3 cycles while din toggles.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         sd_if.din = ~sd_if.din;
         @(posedge clk);
         #1;
         check("reset_hold", sd_if.dout, 1'b0);
      end
      @(negedge clk);
      reset = 1'b0;

      // Basic match, then asynchronous reset while dout is high.
      send("basic", "00110110", "00000001");
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("async_reset", sd_if.dout, 1'b0);
      @(negedge clk);
      reset = 1'b0;

      send("near_miss", "1100111100", "0000000000");
      pulse_reset();

`ifdef SEQ_DET_OVERLAP_EN
      send("overlap", "110110110", "000001001");
`else
      send("overlap", "110110110", "000001000");
`endif
      pulse_reset();

      send("long_run", "11110110", "00000001");
      pulse_reset();

      send("mid_reset_pre", "11011", "00000");
      pulse_reset();
      send("mid_reset_post", "0", "0");
      send("mid_reset_full", "110110", "000001");

      // Drain remaining expectations with a bounded wait.
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
         @(posedge clk);
      end
      #2;
      if (exp_q.size() > 0) begin
         n_total++;
         n_fail++;
         $display("FAIL drain: pending=%0d required=0", exp_q.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
